serial_tx: RTL



---
 rtl/serial_tx_if.sv | 12 +
 rtl/serial_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/serial_tx_if.sv
// Parallel-word handshake into the serial transmitter: source drives DIN/DVALID,
// transmitter answers with DREADY.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] DIN;
    logic              DVALID;
    logic              DREADY;

    modport master (output DIN, output DVALID, input DREADY);
    modport slave  (input DIN, input DVALID, output DREADY);
endinterface

// File: rtl/serial_tx.sv
// UART-framed serial transmitter: start bit, DATA_W bits LSB first, optional even
// parity bit (enabled by macro SERIAL_TX_PARITY_EN), stop bit; CLKDIV clocks per bit.
module serial_tx #(
    parameter int DATA_W = 8,
    parameter int CLKDIV = 16
) (
    input  logic        CLK,
    input  logic        CLR,
    serial_tx_if.slave  bus,
    output logic        TXD,
    output logic        BUSY
);
    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [DIV_W-1:0]    div_cnt, div_n;
    logic [BIT_W-1:0]    bit_cnt, bit_n;
    logic                txd_r, txd_n;
    logic                dready_r, dready_n;
    logic                busy_r, busy_n;
    logic                bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic                par, par_n;
`endif

    assign bit_end = (div_cnt == DIV_W'(CLKDIV - 1));

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= S_IDLE;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            txd_r    <= 1'b1;
            dready_r <= 1'b1;
            busy_r   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            div_cnt  <= div_n;
            bit_cnt  <= bit_n;
            txd_r    <= txd_n;
            dready_r <= dready_n;
            busy_r   <= busy_n;
`ifdef SERIAL_TX_PARITY_EN
            par      <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
`ifdef SERIAL_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            S_IDLE: begin
                if (bus.DVALID && dready_r) begin
                    state_n = S_START;
                    shreg_n = bus.DIN;
                    div_n   = '0;
                    bit_n   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = 1'b0;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    div_n   = '0;
                    state_n = S_DATA;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    div_n   = '0;
                    shreg_n = shreg >> 1;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = par ^ shreg[0];
`endif
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        bit_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    div_n   = '0;
                    state_n = S_STOP;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    div_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        case (state_n)
            S_START:  txd_n = 1'b0;
            S_DATA:   txd_n = shreg_n[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: txd_n = par_n;
`endif
            default:  txd_n = 1'b1;
        endcase
        dready_n = (state_n == S_IDLE);
        busy_n   = (state_n != S_IDLE);
    end

    assign bus.DREADY = dready_r;
    assign TXD        = txd_r;
    assign BUSY       = busy_r;
endmodule
